ct_f_spsram_512x7_ctrl: RTL

CT_F_SPSRAM_512X7_CTRL -- requirements
Module: ct_f_spsram_512x7_ctrl

---
 rtl/ct_f_spsram_512x7_ctrl.sv | 111 +++++++++++
 1 files changed

// File: rtl/ct_f_spsram_512x7_ctrl.sv
// Request/response front end for a 512x7 single-port SRAM macro.
// After reset it optionally fills the array, then serves masked writes and in-order reads.
module ct_f_spsram_512x7_ctrl #(
  parameter bit         INIT_EN  = 1'b1,
  parameter logic [6:0] INIT_VAL = 7'h00
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       req_vld,
  output logic       req_rdy,
  input  logic       req_wr,
  input  logic [8:0] req_addr,
  input  logic [6:0] req_wdata,
  input  logic [6:0] req_wmask,
  output logic       rsp_vld,
  input  logic       rsp_rdy,
  output logic [6:0] rsp_rdata,
  output logic       init_done,
  output logic [8:0] A,
  output logic       CEN,
  output logic       GWEN,
  output logic [6:0] WEN,
  output logic [6:0] D,
  input  logic [6:0] Q
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t     state, state_nxt;
  logic [9:0] init_cnt;
  logic       inflight;
  logic [6:0] fifo_mem [2];
  logic       rd_ptr, wr_ptr;
  logic [1:0] fifo_cnt;
  logic [8:0] a_hold;
  logic [1:0] credit;
  logic       run, pop, push, rd_ok, accept;

  assign rsp_vld   = (fifo_cnt != 2'd0);
  assign rsp_rdata = fifo_mem[rd_ptr];
  assign run       = (state == ST_RUN) && init_done;
  assign pop       = rsp_vld && rsp_rdy;
  assign push      = inflight;
  // Credit covers both buffered and in-flight reads so a captured Q always has a FIFO slot.
  assign credit    = fifo_cnt + {1'b0, inflight};
  assign rd_ok     = (credit < 2'd2) || pop;
  assign req_rdy   = run && (req_wr || rd_ok);
  assign accept    = req_vld && req_rdy;

  always_comb begin
    state_nxt = state;
    A         = a_hold;
    CEN       = 1'b1;
    GWEN      = 1'b1;
    WEN       = '1;
    D         = '0;
    case (state)
      ST_INIT: begin
        // Pins are forced idle while RST is held, even though the state already reads INIT.
        if (!RST) begin
          A    = init_cnt[8:0];
          CEN  = 1'b0;
          GWEN = 1'b0;
          WEN  = '0;
          D    = INIT_VAL;
          if (init_cnt == 10'd511) state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (accept) begin
          A   = req_addr;
          CEN = 1'b0;
          if (req_wr) begin
            GWEN = 1'b0;
            WEN  = ~req_wmask;
            D    = req_wdata;
          end
        end
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= INIT_EN ? ST_INIT : ST_RUN;
      init_cnt    <= '0;
      init_done   <= 1'b0;
      inflight    <= 1'b0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      fifo_cnt    <= '0;
      a_hold      <= '0;
    end else begin
      state  <= state_nxt;
      a_hold <= A;
      if (state == ST_INIT && init_cnt != 10'd511) init_cnt <= init_cnt + 10'd1;
      if (state_nxt == ST_RUN) init_done <= 1'b1;
      inflight <= accept && !req_wr;
      if (push) begin
        fifo_mem[wr_ptr] <= Q;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule
